// File: rtl/xcorr_lag_accumulator.sv
// xcorr_lag_accumulator: windowed cross-correlation of two sample streams over lags -MAX_LAGS..+MAX_LAGS,
// results frozen in HOLD and read through a registered random-access port until the consumer releases them.
module xcorr_lag_accumulator #(
    parameter int MAX_LAGS = 17,
    parameter int DATA_W   = 16,
    parameter int WINDOW   = 256,
    parameter int ACC_W    = 2*DATA_W + $clog2(WINDOW),
    localparam int NUM_LAGS = 2*MAX_LAGS + 1,
    localparam int IW       = $clog2(NUM_LAGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sampleValid,
    output logic                sampleReady,
    input  logic [DATA_W-1:0]   sampleA,
    input  logic [DATA_W-1:0]   sampleB,
    output logic                resultValid,
    input  logic [IW-1:0]       readIndex,
    output logic [ACC_W-1:0]    readData,
    input  logic                readDone,
    output logic                busy
);
    localparam int FW = $clog2(2*MAX_LAGS + 1);
    localparam int WW = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {FILL, ACCUMULATE, HOLD} state_t;

    state_t                    r_state, w_next;
    logic [FW-1:0]             r_fill;
    logic [WW-1:0]             r_win;
    logic signed [DATA_W-1:0]  r_a [MAX_LAGS];
    logic signed [DATA_W-1:0]  r_b [2*MAX_LAGS];
    logic signed [DATA_W-1:0]  w_a;
    logic signed [DATA_W-1:0]  w_b [NUM_LAGS];
    logic signed [2*DATA_W-1:0] w_mul [NUM_LAGS];
    logic signed [ACC_W-1:0]   w_prod [NUM_LAGS];
    logic signed [ACC_W-1:0]   r_acc [NUM_LAGS];
    logic signed [ACC_W-1:0]   r_rd;
    logic                      r_valid;
    logic                      w_xfer, w_fill_done, w_win_done, w_idx_ok;

    assign sampleReady = r_state != HOLD;
    assign busy        = r_state != HOLD;
    assign resultValid = r_valid;
    assign readData    = r_rd;
    assign w_xfer      = sampleValid & sampleReady;
    assign w_fill_done = r_fill == FW'(2*MAX_LAGS - 1);
    assign w_win_done  = r_win == WW'(WINDOW - 1);
    assign w_idx_ok    = {1'b0, readIndex} < (IW+1)'(NUM_LAGS);

    // w_b[k] is B[n-k] for the sample being transferred now; w_a is A[n-MAX_LAGS]
    assign w_a    = r_a[MAX_LAGS-1];
    assign w_b[0] = $signed(sampleB);

    genvar k;
    generate
        for (k = 1; k < NUM_LAGS; k++) begin : g_tap
            assign w_b[k] = r_b[k-1];
        end
        for (k = 0; k < NUM_LAGS; k++) begin : g_mul
            assign w_mul[k]  = (2*DATA_W)'(w_a) * (2*DATA_W)'(w_b[2*MAX_LAGS-k]);
            assign w_prod[k] = ACC_W'(w_mul[k]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= FILL;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL:       w_next = (w_xfer && w_fill_done) ? ACCUMULATE : FILL;
            ACCUMULATE: w_next = (w_xfer && w_win_done) ? HOLD : ACCUMULATE;
            HOLD:       w_next = readDone ? ACCUMULATE : HOLD;
            default:    w_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill  <= '0;
            r_win   <= '0;
            r_valid <= 1'b0;
            r_rd    <= '0;
            for (int i = 0; i < MAX_LAGS; i++) r_a[i] <= '0;
            for (int i = 0; i < 2*MAX_LAGS; i++) r_b[i] <= '0;
            for (int i = 0; i < NUM_LAGS; i++) r_acc[i] <= '0;
        end else begin
            r_valid <= (r_state == ACCUMULATE) && w_xfer && w_win_done;
            r_rd    <= w_idx_ok ? r_acc[readIndex] : '0;
            if (w_xfer) begin
                r_a[0] <= $signed(sampleA);
                for (int i = 1; i < MAX_LAGS; i++) r_a[i] <= r_a[i-1];
                r_b[0] <= $signed(sampleB);
                for (int i = 1; i < 2*MAX_LAGS; i++) r_b[i] <= r_b[i-1];
            end
            if (r_state == FILL && w_xfer)
                r_fill <= r_fill + 1'b1;
            if (r_state == ACCUMULATE && w_xfer) begin
                r_win <= r_win + 1'b1;
                for (int i = 0; i < NUM_LAGS; i++) r_acc[i] <= r_acc[i] + w_prod[i];
            end
            // releasing HOLD starts a fresh window on the retained delay-line history
            if (r_state == HOLD && readDone) begin
                r_win <= '0;
                for (int i = 0; i < NUM_LAGS; i++) r_acc[i] <= '0;
            end
        end
    end
endmodule
